// File: rtl/fetch_sequencer_if.sv
// Decoder-side bundle for fetch_sequencer: branch/halt/stall controls in,
// PC, run status and performance counters out.
interface fetch_sequencer_if #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned CNT_W = 16
);
    logic             stall;
    logic             halt;
    logic             br_take;
    logic             br_rel;
    logic [7:0]       br_offset;
    logic [PC_W-1:0]  br_target;
    logic [PC_W-1:0]  PC;
    logic             fetch_valid;
    logic             DONE;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;

    // master: the decoder / instruction-memory side
    modport master (
        output stall, halt, br_take, br_rel, br_offset, br_target,
        input  PC, fetch_valid, DONE, instr_count, cycle_count
    );

    // slave: the sequencer itself
    modport slave (
        input  stall, halt, br_take, br_rel, br_offset, br_target,
        output PC, fetch_valid, DONE, instr_count, cycle_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and run control: IDLE -> RUN on START falling, RUN -> HALT on
// an unstalled halt, with saturating retired-instruction and cycle counters.
module fetch_sequencer #(
    parameter int unsigned      PC_W       = 10,
    parameter int unsigned      CNT_W      = 16,
    parameter logic [PC_W-1:0]  START_ADDR = '0
) (
    input  logic             CLK,
    input  logic             START,
    fetch_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state;
    logic [PC_W-1:0]  pc;
    logic             done;
    logic [CNT_W-1:0] icnt;
    logic [CNT_W-1:0] ccnt;

    logic [PC_W-1:0]  off_ext;
    logic [CNT_W-1:0] icnt_inc;
    logic [CNT_W-1:0] ccnt_inc;

    always_comb begin
        off_ext  = {{(PC_W-8){bus.br_offset[7]}}, bus.br_offset};
        icnt_inc = (icnt == '1) ? icnt : icnt + CNT_W'(1);
        ccnt_inc = (ccnt == '1) ? ccnt : ccnt + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (START) begin
            state <= IDLE;
            pc    <= START_ADDR;
            done  <= 1'b0;
            icnt  <= '0;
            ccnt  <= '0;
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    ccnt <= ccnt_inc;
                    // stall outranks halt and branch: the instruction is not retired
                    if (bus.stall) begin
                        pc <= pc;
                    end else if (bus.halt) begin
                        state <= HALT;
                        done  <= 1'b1;
                        icnt  <= icnt_inc;
                    end else if (bus.br_take && bus.br_rel) begin
                        pc   <= pc + off_ext;
                        icnt <= icnt_inc;
                    end else if (bus.br_take) begin
                        pc   <= bus.br_target;
                        icnt <= icnt_inc;
                    end else begin
                        pc   <= pc + PC_W'(1);
                        icnt <= icnt_inc;
                    end
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.PC          = pc;
    assign bus.DONE        = done;
    assign bus.instr_count = icnt;
    assign bus.cycle_count = ccnt;
    assign bus.fetch_valid = (state == RUN);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a behavioural model pushes the expected
// post-edge outputs into a queue, which is popped and compared after each edge.
module tb_fetch_sequencer;
    localparam int unsigned PC_W  = 10;
    localparam int unsigned CNT_W = 16;

    typedef struct {
        string            tag;
        logic [PC_W-1:0]  pc;
        logic             done;
        logic             fv;
        logic [CNT_W-1:0] ic;
        logic [CNT_W-1:0] cc;
    } exp_t;

    logic CLK = 1'b0;
    logic START;
    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];

    // model state: 0 idle, 1 run, 2 halt
    int               m_st = 0;
    logic [PC_W-1:0]  m_pc = '0;
    logic             m_done = 1'b0;
    logic [CNT_W-1:0] m_ic = '0;
    logic [CNT_W-1:0] m_cc = '0;

    fetch_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    fetch_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .START_ADDR(10'd0)) dut (
        .CLK   (CLK),
        .START (START),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic h, input logic bt, input logic br,
                         input logic [7:0] off, input logic [PC_W-1:0] tgt);
        bus.stall     = st;
        bus.halt      = h;
        bus.br_take   = bt;
        bus.br_rel    = br;
        bus.br_offset = off;
        bus.br_target = tgt;
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Predict the edge, push the prediction, take the edge, then pop and compare.
    task automatic step(input string tag);
        exp_t e;
        exp_t g;
        int signed off;
        if (START) begin
            m_st = 0; m_pc = '0; m_done = 1'b0; m_ic = '0; m_cc = '0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            m_cc = sat_inc(m_cc);
            if (bus.stall) begin
            end else begin
                m_ic = sat_inc(m_ic);
                if (bus.halt) begin
                    m_st = 2; m_done = 1'b1;
                end else if (bus.br_take && bus.br_rel) begin
                    off  = int'($signed(bus.br_offset));
                    m_pc = PC_W'((int'(m_pc) + off + 1024) % 1024);
                end else if (bus.br_take) begin
                    m_pc = bus.br_target;
                end else begin
                    m_pc = PC_W'((int'(m_pc) + 1) % 1024);
                end
            end
        end
        e.tag = tag; e.pc = m_pc; e.done = m_done; e.fv = (m_st == 1);
        e.ic = m_ic; e.cc = m_cc;
        sbq.push_back(e);
        @(posedge CLK);
        #1;
        g = sbq.pop_front();
        chk({g.tag, ".pc"},   32'(bus.PC),          32'(g.pc));
        chk({g.tag, ".done"}, 32'(bus.DONE),        32'(g.done));
        chk({g.tag, ".fv"},   32'(bus.fetch_valid), 32'(g.fv));
        chk({g.tag, ".ic"},   32'(bus.instr_count), 32'(g.ic));
        chk({g.tag, ".cc"},   32'(bus.cycle_count), 32'(g.cc));
    endtask

    task automatic plain_steps(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 8'h00, '0);
            step(tag);
        end
    endtask

    task automatic reset_and_launch(input string tag);
        START = 1'b1;
        drive(0, 0, 0, 0, 8'h00, '0);
        step({tag, "_rst0"});
        step({tag, "_rst1"});
        START = 1'b0;
        step({tag, "_launch"});
    endtask

    task automatic straight_line(input string tag);
        plain_steps({tag, "_seq"}, 3);
        drive(0, 1, 0, 0, 8'h00, '0);
        step({tag, "_halt"});
        chk({tag, "_final_pc"}, 32'(bus.PC), 32'd3);
        chk({tag, "_final_ic"}, 32'(bus.instr_count), 32'd4);
        chk({tag, "_final_cc"}, 32'(bus.cycle_count), 32'd4);
    endtask

    initial begin
        START = 1'b1;
        drive(0, 0, 0, 0, 8'h00, '0);

        // reset, launch, straight-line halt at PC=3
        reset_and_launch("r1");
        straight_line("line1");

        // halt state ignores noise
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), PC_W'($urandom_range(0, 1023)));
            step("halt_noise");
        end
        chk("halt_frozen_done", 32'(bus.DONE), 32'd1);

        // re-launch: DONE falls one edge after START
        START = 1'b1;
        drive(0, 0, 0, 0, 8'h00, '0);
        step("relaunch_start");
        START = 1'b0;
        step("relaunch_run");
        straight_line("line2");

        // branches
        reset_and_launch("r2");
        plain_steps("to5", 5);
        drive(0, 0, 1, 1, 8'hFE, '0);
        step("br_rel_back2");
        chk("br_rel_pc3", 32'(bus.PC), 32'd3);
        drive(0, 0, 1, 0, 8'h00, 10'h3FF);
        step("br_abs_3ff");
        chk("br_abs_pc", 32'(bus.PC), 32'h3FF);
        plain_steps("wrap", 1);
        chk("wrap_pc0", 32'(bus.PC), 32'd0);

        // stall priority at PC=7
        plain_steps("to7", 7);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 1, 8'h10, 10'h055);
            step("stall");
        end
        chk("stall_pc7", 32'(bus.PC), 32'd7);
        drive(0, 1, 1, 1, 8'h10, 10'h055);
        step("stall_release_halt");
        chk("stall_release_done", 32'(bus.DONE), 32'd1);

        // START mid-run at PC=12
        reset_and_launch("r3");
        plain_steps("to12", 12);
        chk("mid_ic12", 32'(bus.instr_count), 32'd12);
        START = 1'b1;
        step("mid_abort");
        START = 1'b0;
        step("mid_relaunch");

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
